// File: rtl/dp_bsr_ctrl_pkg.sv
// Shared types for the boundary scan register chain sequencer.
package dp_bsr_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    // Sequencer phases: one capture, width shifts, optional update, then respond.
    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SHIFT   = 3'd2,
        UPDATE  = 3'd3,
        DONE    = 3'd4
    } bsr_ctrl_state_t;

endpackage

// File: rtl/dp_bsr_ctrl.sv
// Host-side sequencer for the debug boundary scan register chain.
// Runs one capture/shift/(update) transaction per request and returns the
// captured parallel inputs as a response.
// Ports:
//   iclk, iresetn            clock, async active-low reset
//   req_valid/ready/data/mode/upd   transaction request
//   rsp_valid/ready/data     captured data response
//   busy                     high whenever not idle
//   sdi, sdo                 serial path to/from the chain (LSB first)
//   mode, shift_dr, clk_dr, update_dr   chain control
module dp_bsr_ctrl
    import dp_bsr_ctrl_pkg::*;
#(
    parameter int unsigned width = 8
) (
    input  logic             iclk,
    input  logic             iresetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [width-1:0] req_data,
    input  logic             req_mode,
    input  logic             req_upd,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [width-1:0] rsp_data,
    output logic             busy,
    output logic             sdi,
    input  logic             sdo,
    output logic             mode,
    output logic             shift_dr,
    output logic             clk_dr,
    output logic             update_dr
);

    localparam int unsigned      CNT_W    = $clog2(width + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(width - 1);

    bsr_ctrl_state_t  state_q, state_d;
    logic [width-1:0] sreg_q, sreg_d, sreg_shift;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             upd_q, upd_d;
    logic             mode_q, mode_d;

    // Shift right: sdo enters at the top, sreg[0] leaves on sdi.
    if (width == 1) begin : g_shift_one
        assign sreg_shift = sdo;
    end else begin : g_shift_many
        assign sreg_shift = {sdo, sreg_q[width-1:1]};
    end

    // State and datapath registers.
    always_ff @(posedge iclk or negedge iresetn) begin
        if (!iresetn) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            upd_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            upd_q   <= upd_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        upd_d   = upd_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    sreg_d  = req_data;
                    upd_d   = req_upd;
                    mode_d  = req_mode;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                sreg_d = sreg_shift;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = upd_q ? UPDATE : DONE;
                end
            end
            UPDATE: begin
                state_d = DONE;
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state or taken straight from registers.
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_data  = sreg_q;
    assign sdi       = sreg_q[0];
    assign mode      = mode_q;
    assign clk_dr    = (state_q == CAPTURE) || (state_q == SHIFT);
    assign shift_dr  = (state_q == SHIFT);
    assign update_dr = (state_q == UPDATE);

endmodule

// File: tb/tb_dp_bsr_ctrl.sv
// Directed bench for dp_bsr_ctrl: width-8 and width-1 instances, each driving
// a small behavioural boundary scan chain (capture, shift toward cell 0, update).
module tb_dp_bsr_ctrl;

    logic clk;
    logic iresetn;

    // width = 8 instance
    logic       req_valid8, req_ready8, req_mode8, req_upd8;
    logic [7:0] req_data8;
    logic       rsp_valid8, rsp_ready8;
    logic [7:0] rsp_data8;
    logic       busy8, sdi8, sdo8, mode8, shift_dr8, clk_dr8, update_dr8;

    // width = 1 instance
    logic       req_valid1, req_ready1, req_mode1, req_upd1;
    logic [0:0] req_data1;
    logic       rsp_valid1, rsp_ready1;
    logic [0:0] rsp_data1;
    logic       busy1, sdi1, sdo1, mode1, shift_dr1, clk_dr1, update_dr1;

    // Chain models: sdi enters the top cell, sdo is cell 0.
    logic [7:0] pdi8, cap8, pdo8;
    logic [0:0] pdi1, cap1, pdo1;

    int n_tests;
    int n_fail;

    dp_bsr_ctrl #(.width(8)) dut8 (
        .iclk(clk), .iresetn(iresetn),
        .req_valid(req_valid8), .req_ready(req_ready8), .req_data(req_data8),
        .req_mode(req_mode8), .req_upd(req_upd8),
        .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready8), .rsp_data(rsp_data8),
        .busy(busy8), .sdi(sdi8), .sdo(sdo8), .mode(mode8),
        .shift_dr(shift_dr8), .clk_dr(clk_dr8), .update_dr(update_dr8)
    );

    dp_bsr_ctrl #(.width(1)) dut1 (
        .iclk(clk), .iresetn(iresetn),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_data(req_data1),
        .req_mode(req_mode1), .req_upd(req_upd1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
        .busy(busy1), .sdi(sdi1), .sdo(sdo1), .mode(mode1),
        .shift_dr(shift_dr1), .clk_dr(clk_dr1), .update_dr(update_dr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cap8 = 8'h00; pdo8 = 8'h00;
        cap1 = 1'b0;  pdo1 = 1'b0;
    end

    always @(posedge clk) begin
        if (clk_dr8) cap8 <= shift_dr8 ? {sdi8, cap8[7:1]} : pdi8;
        if (update_dr8) pdo8 <= cap8;
        if (clk_dr1) cap1 <= shift_dr1 ? sdi1 : pdi1;
        if (update_dr1) pdo1 <= cap1;
    end
    assign sdo8 = cap8[0];
    assign sdo1 = cap1[0];

    // Steps from cycle 1 until rsp_valid, tallying control activity per cycle.
    task automatic observe8(output int rsp_cyc, output int n_shift, output int n_clk,
                            output int n_upd, output int upd_cyc, output int n_rdy);
        int cyc;
        cyc = 1; rsp_cyc = -1; n_shift = 0; n_clk = 0; n_upd = 0; upd_cyc = -1; n_rdy = 0;
        while (rsp_cyc < 0 && cyc <= 40) begin
            if (req_ready8) n_rdy++;
            if (rsp_valid8) begin
                rsp_cyc = cyc;
            end else begin
                if (shift_dr8) n_shift++;
                if (clk_dr8) n_clk++;
                if (update_dr8) begin n_upd++; upd_cyc = cyc; end
                @(posedge clk); #1;
                cyc++;
            end
        end
    endtask

    task automatic observe1(output int rsp_cyc, output int n_shift, output int n_upd);
        int cyc;
        cyc = 1; rsp_cyc = -1; n_shift = 0; n_upd = 0;
        while (rsp_cyc < 0 && cyc <= 20) begin
            if (rsp_valid1) begin
                rsp_cyc = cyc;
            end else begin
                if (shift_dr1) n_shift++;
                if (update_dr1) n_upd++;
                @(posedge clk); #1;
                cyc++;
            end
        end
    endtask

    task automatic consume8();
        rsp_ready8 = 1'b1;
        @(posedge clk); #1;
        rsp_ready8 = 1'b0;
    endtask

    task automatic consume1();
        rsp_ready1 = 1'b1;
        @(posedge clk); #1;
        rsp_ready1 = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] ctl;
        iresetn = 1'b0;
        #3;
        ctl = {req_ready8, rsp_valid8, busy8, shift_dr8, clk_dr8, update_dr8, sdi8, mode8};
        n_tests++;
        if (ctl !== 8'b1000_0000) begin
            n_fail++; $display("FAIL reset_ctl8: got %b want 10000000", ctl);
        end
        n_tests++;
        if (rsp_data8 !== 8'h00) begin
            n_fail++; $display("FAIL reset_data8: got %h want 00", rsp_data8);
        end
        ctl = {req_ready1, rsp_valid1, busy1, shift_dr1, clk_dr1, update_dr1, sdi1, mode1};
        n_tests++;
        if (ctl !== 8'b1000_0000 || rsp_data1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctl1: got %b data %b want 10000000 data 0", ctl, rsp_data1);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        iresetn = 1'b1;
        // A stray rsp_ready while idle must not disturb anything.
        rsp_ready8 = 1'b1;
        @(posedge clk); #1;
        rsp_ready8 = 1'b0;
        n_tests++;
        if (busy8 !== 1'b0 || rsp_valid8 !== 1'b0 || req_ready8 !== 1'b1) begin
            n_fail++; $display("FAIL idle_rsp_ready: busy %b rsp_valid %b req_ready %b want 0 0 1",
                               busy8, rsp_valid8, req_ready8);
        end
    endtask

    task automatic test_capture_update();
        int rc, ns, nc, nu, uc, nr;
        pdi8 = 8'h3C;
        req_data8 = 8'hA5; req_mode8 = 1'b1; req_upd8 = 1'b1; req_valid8 = 1'b1;
        @(posedge clk); #1;
        req_valid8 = 1'b0;
        n_tests++;
        if (mode8 !== 1'b1 || busy8 !== 1'b1 || clk_dr8 !== 1'b1 || shift_dr8 !== 1'b0) begin
            n_fail++; $display("FAIL cu_capture: mode %b busy %b clk_dr %b shift_dr %b want 1 1 1 0",
                               mode8, busy8, clk_dr8, shift_dr8);
        end
        observe8(rc, ns, nc, nu, uc, nr);
        n_tests++;
        if (rc != 11) begin n_fail++; $display("FAIL cu_rsp_cycle: got %0d want 11", rc); end
        n_tests++;
        if (rsp_data8 !== 8'h3C) begin n_fail++; $display("FAIL cu_rsp_data: got %h want 3c", rsp_data8); end
        n_tests++;
        if (nu != 1 || uc != 10) begin
            n_fail++; $display("FAIL cu_update: pulses %0d at %0d want 1 at 10", nu, uc);
        end
        n_tests++;
        if (ns != 8 || nc != 9) begin
            n_fail++; $display("FAIL cu_counts: shift %0d clk %0d want 8 9", ns, nc);
        end
        n_tests++;
        if (pdo8 !== 8'hA5) begin n_fail++; $display("FAIL cu_pdo: got %h want a5", pdo8); end
        consume8();
        n_tests++;
        if (req_ready8 !== 1'b1 || busy8 !== 1'b0 || mode8 !== 1'b1) begin
            n_fail++; $display("FAIL cu_return: req_ready %b busy %b mode %b want 1 0 1",
                               req_ready8, busy8, mode8);
        end
    endtask

    task automatic test_sample();
        int rc, ns, nc, nu, uc, nr;
        pdi8 = 8'hF0;
        req_data8 = 8'h5A; req_mode8 = 1'b0; req_upd8 = 1'b0; req_valid8 = 1'b1;
        @(posedge clk); #1;
        req_valid8 = 1'b0;
        n_tests++;
        if (mode8 !== 1'b0) begin n_fail++; $display("FAIL sm_mode: got %b want 0", mode8); end
        observe8(rc, ns, nc, nu, uc, nr);
        n_tests++;
        if (rc != 10) begin n_fail++; $display("FAIL sm_rsp_cycle: got %0d want 10", rc); end
        n_tests++;
        if (rsp_data8 !== 8'hF0) begin n_fail++; $display("FAIL sm_rsp_data: got %h want f0", rsp_data8); end
        n_tests++;
        if (nu != 0 || pdo8 !== 8'hA5) begin
            n_fail++; $display("FAIL sm_no_update: pulses %0d pdo %h want 0 a5", nu, pdo8);
        end
        n_tests++;
        if (ns != 8 || nc != 9) begin
            n_fail++; $display("FAIL sm_counts: shift %0d clk %0d want 8 9", ns, nc);
        end
        consume8();
    endtask

    task automatic test_back_to_back();
        int rc, ns, nc, nu, uc, nr, bad;
        pdi8 = 8'h99;
        req_data8 = 8'h01; req_mode8 = 1'b1; req_upd8 = 1'b1; req_valid8 = 1'b1;
        @(posedge clk); #1;
        req_data8 = 8'h80;              // second request waits with valid held high
        observe8(rc, ns, nc, nu, uc, nr);
        n_tests++;
        if (rc != 11 || nr != 0) begin
            n_fail++; $display("FAIL b2b_first: rsp cycle %0d ready cycles %0d want 11 0", rc, nr);
        end
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid8 !== 1'b1 || rsp_data8 !== 8'h99 || req_ready8 !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL b2b_hold: unstable cycles %0d want 0", bad); end
        n_tests++;
        if (pdo8 !== 8'h01) begin n_fail++; $display("FAIL b2b_pdo1: got %h want 01", pdo8); end
        pdi8 = 8'h42;
        consume8();
        n_tests++;
        if (busy8 !== 1'b0 || req_ready8 !== 1'b1) begin
            n_fail++; $display("FAIL b2b_gap: busy %b req_ready %b want 0 1", busy8, req_ready8);
        end
        @(posedge clk); #1;
        req_valid8 = 1'b0;
        n_tests++;
        if (busy8 !== 1'b1 || clk_dr8 !== 1'b1 || shift_dr8 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_accept2: busy %b clk_dr %b shift_dr %b want 1 1 0",
                               busy8, clk_dr8, shift_dr8);
        end
        observe8(rc, ns, nc, nu, uc, nr);
        n_tests++;
        if (rc != 11 || rsp_data8 !== 8'h42) begin
            n_fail++; $display("FAIL b2b_second: cycle %0d data %h want 11 42", rc, rsp_data8);
        end
        consume8();
        n_tests++;
        if (pdo8 !== 8'h80) begin n_fail++; $display("FAIL b2b_pdo2: got %h want 80", pdo8); end
    endtask

    task automatic test_reset_mid_shift();
        int rc, ns, nc, nu, uc, nr, bad;
        logic [7:0] ctl;
        pdi8 = 8'h11;
        req_data8 = 8'h77; req_mode8 = 1'b1; req_upd8 = 1'b1; req_valid8 = 1'b1;
        @(posedge clk); #1;
        req_valid8 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end   // fourth SHIFT cycle
        n_tests++;
        if (shift_dr8 !== 1'b1 || mode8 !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre: shift_dr %b mode %b want 1 1", shift_dr8, mode8);
        end
        #2;
        iresetn = 1'b0;
        #1;
        ctl = {req_ready8, rsp_valid8, busy8, shift_dr8, clk_dr8, update_dr8, sdi8, mode8};
        n_tests++;
        if (ctl !== 8'b1000_0000 || rsp_data8 !== 8'h00) begin
            n_fail++; $display("FAIL rst_mid: ctl %b data %h want 10000000 00", ctl, rsp_data8);
        end
        @(negedge clk);
        iresetn = 1'b1;
        bad = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (rsp_valid8 !== 1'b0 || busy8 !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0 || pdo8 !== 8'h80) begin
            n_fail++; $display("FAIL rst_aborted: bad cycles %0d pdo %h want 0 80", bad, pdo8);
        end
        pdi8 = 8'h5C;
        req_data8 = 8'hC3; req_mode8 = 1'b0; req_upd8 = 1'b1; req_valid8 = 1'b1;
        @(posedge clk); #1;
        req_valid8 = 1'b0;
        observe8(rc, ns, nc, nu, uc, nr);
        n_tests++;
        if (rc != 11 || rsp_data8 !== 8'h5C) begin
            n_fail++; $display("FAIL rst_next: cycle %0d data %h want 11 5c", rc, rsp_data8);
        end
        consume8();
        n_tests++;
        if (pdo8 !== 8'hC3) begin n_fail++; $display("FAIL rst_next_pdo: got %h want c3", pdo8); end
    endtask

    task automatic test_width1();
        int rc, ns, nu;
        pdi1 = 1'b0;
        req_data1 = 1'b1; req_mode1 = 1'b1; req_upd1 = 1'b1; req_valid1 = 1'b1;
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        observe1(rc, ns, nu);
        n_tests++;
        if (rc != 4 || ns != 1 || nu != 1) begin
            n_fail++; $display("FAIL w1_timing: rsp %0d shift %0d upd %0d want 4 1 1", rc, ns, nu);
        end
        n_tests++;
        if (rsp_data1 !== 1'b0) begin n_fail++; $display("FAIL w1_rsp: got %b want 0", rsp_data1); end
        consume1();
        n_tests++;
        if (pdo1 !== 1'b1) begin n_fail++; $display("FAIL w1_pdo: got %b want 1", pdo1); end
        pdi1 = 1'b1;
        req_data1 = 1'b0; req_upd1 = 1'b0; req_valid1 = 1'b1;
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        observe1(rc, ns, nu);
        n_tests++;
        if (rc != 3 || rsp_data1 !== 1'b1 || pdo1 !== 1'b1) begin
            n_fail++; $display("FAIL w1_sample: rsp %0d data %b pdo %b want 3 1 1", rc, rsp_data1, pdo1);
        end
        consume1();
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        iresetn = 1'b0;
        req_valid8 = 1'b0; req_data8 = 8'h00; req_mode8 = 1'b0; req_upd8 = 1'b0; rsp_ready8 = 1'b0;
        req_valid1 = 1'b0; req_data1 = 1'b0;  req_mode1 = 1'b0; req_upd1 = 1'b0; rsp_ready1 = 1'b0;
        pdi8 = 8'h00; pdi1 = 1'b0;
        test_reset();
        test_capture_update();
        test_sample();
        test_back_to_back();
        test_reset_mid_shift();
        test_width1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/dp_bsr_ctrl.md
# dp_bsr_ctrl

Host-side sequencer for the debug boundary scan register chain. It accepts one scan transaction per request: parallel write data plus a mode bit. For each transaction it drives capture, shift and update on the chain, collecting the captured parallel inputs serially. It returns them as a response. It sits between an internal debug master and a `dp_bsr` instance, replacing TAP-driven sequencing when the chain is operated from on-chip logic.

## Interface
Parameters:
- `width`, default 8: chain length in cells; must be ≥ 1.

Ports:
- `iclk` in 1: internal clock; all logic on its rising edge.
- `iresetn` in 1: internal reset, asynchronous, active-low.
- `req_valid` in 1: transaction request.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_data` in `width`: value to shift into the chain; bit i lands in cell i.
- `req_mode` in 1: mode value applied to the chain for this transaction.
- `req_upd` in 1: 1 runs the UPDATE step; 0 is capture/shift only (sample).
- `rsp_valid` out 1: captured data available.
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_data` out `width`: captured `pdi` value; bit i came from cell i.
- `busy` out 1: high in any state other than IDLE.
- `sdi` out 1: to chain serial input.
- `sdo` in 1: from chain serial output.
- `mode`, `shift_dr`, `clk_dr`, `update_dr` out 1 each: chain control.

## Operation
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE, DONE.
- **IDLE**
  - `req_ready`=1.
  - On handshake: load shift register `sreg`←`req_data`, latch `upd_q`←`req_upd`, load `mode`←`req_mode`, go to CAPTURE.
- **CAPTURE** (1 cycle): `clk_dr`=1, `shift_dr`=0, so the chain loads `pdi`. Clear counter `cnt`←0. Go to SHIFT.
- **SHIFT** (exactly `width` cycles)
  - `clk_dr`=1, `shift_dr`=1, `sdi`=`sreg[0]`.
  - Each cycle: `sreg`←{`sdo`, `sreg[width-1:1]`} and `cnt`++.
  - When `cnt`==`width`-1, leave SHIFT: go to UPDATE if `upd_q`, else DONE.
- **UPDATE** (1 cycle): `update_dr`=1, `clk_dr`=0, `shift_dr`=0. Go to DONE.
- **DONE**: `rsp_valid`=1 and `rsp_data`=`sreg` (holds the captured value). On `rsp_ready`, go to IDLE.
- Outside the states above, `clk_dr`, `shift_dr` and `update_dr` are 0.
- `sdi` is `sreg[0]` at all times; its value is don't-care outside SHIFT.
- `mode` holds its latched value between transactions. It changes only on request acceptance.
- `cnt` width is `$clog2(width+1)`. For `width`=1, SHIFT lasts 1 cycle.
- Bit order is LSB first in both directions.
  - The first bit driven on `sdi` ends in cell 0.
  - The first bit sampled from `sdo` is cell 0's captured value.
- Error cases:
  - `req_valid` outside IDLE is ignored, since `req_ready`=0.
  - `rsp_ready` without `rsp_valid` is ignored.
- DONE with `rsp_ready` held high returns to IDLE. A pending request is accepted on the following cycle, not the same cycle.

## Timing
- Reset (asynchronous, immediate, including mid-transaction):
  - State→IDLE; `sreg`, `cnt`→0; `mode`→0.
  - `req_ready`=1; `rsp_valid`=0; `rsp_data`=0; `busy`=0.
  - `shift_dr`, `clk_dr`, `update_dr` = 0; `sdi`=0.
  - The chain is left as-is. An aborted transaction produces no response.
- Cycle numbering, with the accept edge as cycle 0:
  - CAPTURE in cycle 1.
  - SHIFT in cycles 2 to `width`+1.
  - UPDATE in cycle `width`+2.
  - `rsp_valid` first high in cycle `width`+3 (cycle `width`+2 when `req_upd`=0).
- `sdo` is sampled on the same edge at which the chain shifts. The chain's `sdo` is its registered last-cell output.
- All outputs are registered or decoded directly from state. There is no combinational path from `req_*` or `sdo` to any output.
- Throughput: one transaction per `width`+4 cycles (`width`+3 without update) when `rsp_ready` is tied high.

## Structure
- Package `dp_bsr_ctrl_pkg`: state enum `bsr_ctrl_state_t` (IDLE, CAPTURE, SHIFT, UPDATE, DONE).
- Single flat module; no sub-module.
- The chain (`dp_bsr`) is instantiated only in the testbench and in the integration level, not inside this block.

## Test plan
All scenarios use `width`=8 with a `dp_bsr` instance in the bench.
- `pdi`=0x3C, request `req_data`=0xA5, `req_mode`=1, `req_upd`=1:
  - `rsp_data`=0x3C, `rsp_valid` at cycle 11.
  - `update_dr` pulses once at cycle 10.
  - `pdo`=0xA5 afterward.
- `req_upd`=0, `pdi`=0xF0:
  - `rsp_data`=0xF0 at cycle 10.
  - `update_dr` never asserts; `pdo` unchanged.
- Back-to-back requests 0x01 then 0x80 with `rsp_ready` held at 0 for 5 cycles:
  - `rsp_valid` and `rsp_data` stay stable; `req_ready`=0 throughout.
  - Second request accepted the cycle after the response handshake.
  - Final `pdo`=0x80.
- Reset asserted in SHIFT cycle 4:
  - All outputs go to their reset values immediately.
  - No `rsp_valid`; `mode`=0.
  - Next transaction completes normally.
- `shift_dr` count check: exactly 8 cycles with `shift_dr`=1 per transaction; `clk_dr` high for exactly 9 cycles.
- `width`=1 build: `req_data`=1, `pdi`=0 → `rsp_data`=0, `pdo`=1, response at cycle 4.
